// File: rtl/imem_loadable.sv
// Loadable, byte-addressed instruction memory.
// After reset a sweep zeroes every byte. A byte-wide load port then writes a
// program at runtime. Fetches return INST_BYTES bytes, big-endian, with
// addresses wrapping modulo DEPTH. Results are registered one cycle after the
// request and are held while the pipeline is stalled.
module imem_loadable #(
  parameter int ADDR_W     = 8,
  parameter int INST_BYTES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         pc,
  input  logic                      fetch_req,
  input  logic                      stall,
  input  logic                      load_en,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [7:0]                load_data,
  output logic                      ready,
  output logic [8*INST_BYTES-1:0]   inst,
  output logic                      inst_valid,
  output logic                      misaligned
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW    = 8 * INST_BYTES;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [7:0]        mem_r [DEPTH];

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [7:0]        wr_data_s;
  logic [IW-1:0]     rd_word_s;
  logic              misalign_s;

  // Choose the single memory write source: clear sweep or runtime byte load.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = clr_ptr_r;
    wr_data_s = 8'h00;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      wr_en_s = 1'b1;
    end else if (load_en) begin
      wr_en_s   = 1'b1;
      wr_addr_s = load_addr;
      wr_data_s = load_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Gather the instruction bytes; the lowest address lands in the top byte and
  // the per-byte address wraps naturally at ADDR_W bits.
  always_comb begin
    rd_word_s = {IW{1'b0}};
    for (int k = 0; k < INST_BYTES; k++) begin
      rd_word_s[IW-1-8*k -: 8] = mem_r[pc + ADDR_W'(k)];
    end
  end

  // Flag a pc whose low bits are not a multiple of the instruction size.
  always_comb begin
    misalign_s = ((pc & ADDR_W'(INST_BYTES - 1)) != {ADDR_W{1'b0}});
  end

  // Byte array write port; reads above see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Sweep/run state machine and the registered fetch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      clr_ptr_r  <= {ADDR_W{1'b0}};
      ready      <= 1'b0;
      inst       <= {IW{1'b0}};
      inst_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
          if (clr_ptr_r == {ADDR_W{1'b1}}) begin
            state_r <= ST_RUN;
            ready   <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
          if (!stall) begin
            if (fetch_req) begin
              inst       <= rd_word_s;
              inst_valid <= 1'b1;
              misaligned <= misalign_s;
            end else begin
              inst_valid <= 1'b0;
              misaligned <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= ST_CLEAR;
          clr_ptr_r  <= {ADDR_W{1'b0}};
          ready      <= 1'b0;
          inst       <= {IW{1'b0}};
          inst_valid <= 1'b0;
          misaligned <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: instance 0 uses the defaults
// (ADDR_W=8, INST_BYTES=2), instance 1 uses ADDR_W=10, INST_BYTES=4.
// Stimulus pushes expected fetch results; a negedge monitor checks every
// cycle's outputs against the behaviour implied by the previous edge.
module tb_imem_loadable;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v       [2];
  logic [9:0] pc_v        [2];
  logic       fetch_req_v [2];
  logic       stall_v     [2];
  logic       load_en_v   [2];
  logic [9:0] load_addr_v [2];
  logic [7:0] load_data_v [2];

  logic        rdy_a, vld_a, mis_a;
  logic [15:0] inst_a;
  logic        rdy_b, vld_b, mis_b;
  logic [31:0] inst_b;

  imem_loadable #(.ADDR_W(8), .INST_BYTES(2)) dut_a (
    .clk(clk), .rst(rst_v[0]), .pc(pc_v[0][7:0]), .fetch_req(fetch_req_v[0]),
    .stall(stall_v[0]), .load_en(load_en_v[0]), .load_addr(load_addr_v[0][7:0]),
    .load_data(load_data_v[0]), .ready(rdy_a), .inst(inst_a),
    .inst_valid(vld_a), .misaligned(mis_a)
  );

  imem_loadable #(.ADDR_W(10), .INST_BYTES(4)) dut_b (
    .clk(clk), .rst(rst_v[1]), .pc(pc_v[1]), .fetch_req(fetch_req_v[1]),
    .stall(stall_v[1]), .load_en(load_en_v[1]), .load_addr(load_addr_v[1]),
    .load_data(load_data_v[1]), .ready(rdy_b), .inst(inst_b),
    .inst_valid(vld_b), .misaligned(mis_b)
  );

  logic [31:0] obs_inst [2];
  logic        obs_vld  [2];
  logic        obs_mis  [2];
  logic        obs_rdy  [2];

  // Present both instances through common 32-bit views.
  always_comb begin
    obs_inst[0] = {16'h0000, inst_a};
    obs_inst[1] = inst_b;
    obs_vld[0]  = vld_a;
    obs_vld[1]  = vld_b;
    obs_mis[0]  = mis_a;
    obs_mis[1]  = mis_b;
    obs_rdy[0]  = rdy_a;
    obs_rdy[1]  = rdy_b;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q [$];   // {instance id, misaligned, inst}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge snapshot: inputs seen by the edge and outputs just before it.
  bit          seen      [2];
  logic        ev_rst    [2];
  logic        ev_rdy    [2];
  logic        ev_stall  [2];
  logic        ev_req    [2];
  logic        prev_vld  [2];
  logic        prev_mis  [2];
  logic [31:0] prev_inst [2];

  // Capture what each active edge acted upon.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      seen[i]      <= 1'b1;
      ev_rst[i]    <= rst_v[i];
      ev_rdy[i]    <= obs_rdy[i];
      ev_stall[i]  <= stall_v[i];
      ev_req[i]    <= fetch_req_v[i];
      prev_vld[i]  <= obs_vld[i];
      prev_mis[i]  <= obs_mis[i];
      prev_inst[i] <= obs_inst[i];
    end
  end

  task automatic check_one(input int i);
    logic [33:0] e;
    if (!seen[i]) return;
    if (ev_rst[i]) begin
      chk("reset_inst", obs_inst[i], 32'h0);
      chk("reset_valid", 32'(obs_vld[i]), 32'h0);
      chk("reset_misaligned", 32'(obs_mis[i]), 32'h0);
      chk("reset_ready", 32'(obs_rdy[i]), 32'h0);
    end else if (!ev_rdy[i]) begin
      chk("clear_valid", 32'(obs_vld[i]), 32'h0);
      chk("clear_inst", obs_inst[i], 32'h0);
    end else if (ev_stall[i]) begin
      chk("stall_hold_inst", obs_inst[i], prev_inst[i]);
      chk("stall_hold_valid", 32'(obs_vld[i]), 32'(prev_vld[i]));
      chk("stall_hold_misaligned", 32'(obs_mis[i]), 32'(prev_mis[i]));
      chk("run_ready", 32'(obs_rdy[i]), 32'h1);
    end else if (ev_req[i]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_fetch: inst %h seen with empty scoreboard", obs_inst[i]);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_instance", 32'(e[33]), 32'(i));
        chk("fetch_inst", obs_inst[i], e[31:0]);
        chk("fetch_misaligned", 32'(obs_mis[i]), 32'(e[32]));
        chk("fetch_valid", 32'(obs_vld[i]), 32'h1);
      end
    end else begin
      chk("idle_valid", 32'(obs_vld[i]), 32'h0);
      chk("idle_misaligned", 32'(obs_mis[i]), 32'h0);
      chk("idle_hold_inst", obs_inst[i], prev_inst[i]);
    end
  endtask

  // Monitor: check both instances away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_one(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int i, input logic [9:0] addr, input logic [7:0] data);
    load_en_v[i]   = 1'b1;
    load_addr_v[i] = addr;
    load_data_v[i] = data;
    tick();
    load_en_v[i] = 1'b0;
  endtask

  task automatic do_fetch(input int i, input logic [9:0] addr, input logic [31:0] exp_inst,
                          input logic exp_mis);
    fetch_req_v[i] = 1'b1;
    pc_v[i]        = addr;
    exp_q.push_back({i[0], exp_mis, exp_inst});
    tick();
    fetch_req_v[i] = 1'b0;
  endtask

  task automatic sweep(input logic do_a, input logic do_b);
    int first [2];
    first[0] = 0;
    first[1] = 0;
    if (do_a) rst_v[0] = 1'b1;
    if (do_b) rst_v[1] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    for (int e = 1; e <= 1100; e++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (first[i] == 0 && obs_rdy[i]) first[i] = e;
      end
      if ((!do_a || first[0] != 0) && (!do_b || first[1] != 0)) break;
    end
    if (do_a) chk("sweep_edges_a", 32'(first[0]), 32'd256);
    if (do_b) chk("sweep_edges_b", 32'(first[1]), 32'd1024);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i]       = 1'b1;
      pc_v[i]        = 10'h000;
      fetch_req_v[i] = 1'b0;
      stall_v[i]     = 1'b0;
      load_en_v[i]   = 1'b0;
      load_addr_v[i] = 10'h000;
      load_data_v[i] = 8'h00;
    end

    // Reset both, count edges until ready.
    sweep(1'b1, 1'b1);

    // Cleared memory reads zero.
    do_fetch(0, 10'h010, 32'h0000, 1'b0);

    // Load then back-to-back fetches.
    do_load(0, 10'h004, 8'h70);
    do_load(0, 10'h005, 8'h00);
    do_load(0, 10'h006, 8'hE0);
    do_load(0, 10'h007, 8'hFF);
    do_fetch(0, 10'h004, 32'h7000, 1'b0);
    do_fetch(0, 10'h006, 32'hE0FF, 1'b0);
    tick();

    // Wrap-around and misaligned fetch, then idle keeps inst.
    do_load(0, 10'h0FF, 8'hAB);
    do_load(0, 10'h000, 8'hCD);
    do_fetch(0, 10'h0FF, 32'hABCD, 1'b1);
    tick();
    chk("wrap_idle_inst", obs_inst[0], 32'hABCD);
    chk("wrap_idle_valid", 32'(obs_vld[0]), 32'h0);

    // Stall holds outputs for three cycles.
    do_fetch(0, 10'h004, 32'h7000, 1'b0);
    stall_v[0]     = 1'b1;
    fetch_req_v[0] = 1'b1;
    pc_v[0]        = 10'h006;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_inst", obs_inst[0], 32'h7000);
      chk("stall_valid", 32'(obs_vld[0]), 32'h1);
    end
    stall_v[0] = 1'b0;
    do_fetch(0, 10'h006, 32'hE0FF, 1'b0);
    tick();

    // Same-edge load and fetch of one byte: old data first, then new.
    do_load(0, 10'h020, 8'h11);
    load_en_v[0]   = 1'b1;
    load_addr_v[0] = 10'h020;
    load_data_v[0] = 8'h22;
    do_fetch(0, 10'h020, 32'h1100, 1'b0);
    load_en_v[0] = 1'b0;
    do_fetch(0, 10'h020, 32'h2200, 1'b0);
    tick();

    // Reset mid-run wipes memory.
    sweep(1'b1, 1'b0);
    do_fetch(0, 10'h004, 32'h0000, 1'b0);
    do_fetch(0, 10'h020, 32'h0000, 1'b0);
    tick();

    // Wide configuration: wrap and aligned fetches.
    do_load(1, 10'h3FE, 8'h12);
    do_load(1, 10'h3FF, 8'h34);
    do_load(1, 10'h000, 8'h56);
    do_load(1, 10'h001, 8'h78);
    do_fetch(1, 10'h3FE, 32'h12345678, 1'b1);
    do_load(1, 10'h100, 8'hAA);
    do_load(1, 10'h101, 8'hBB);
    do_load(1, 10'h102, 8'hCC);
    do_load(1, 10'h103, 8'hDD);
    do_fetch(1, 10'h100, 32'hAABBCCDD, 1'b0);
    do_fetch(1, 10'h101, 32'hBBCCDD00, 1'b1);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, synchronous, byte-addressed instruction memory. Successor to the hardcoded 8-bit-PC / 16-bit-instruction ROM.
- Contents are written at runtime through a byte load port, so a test program can be downloaded instead of compiled in.
- After reset, a sweep state machine clears every byte to zero.
- Fetch has one-cycle registered latency, with valid and stall handling. Sits between the PC register and the decoder.

Parameters:
- ADDR_W, 8, byte-address width. DEPTH = 2**ADDR_W bytes.
- INST_BYTES, 2, bytes per instruction. Legal values are 1, 2 and 4. Instruction width IW = 8*INST_BYTES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- pc  input  ADDR_W  byte address of the instruction to fetch
- fetch_req  input  1  fetch request, sampled when ready=1 and stall=0
- stall  input  1  pipeline stall; freezes all fetch outputs
- load_en  input  1  byte write enable
- load_addr  input  ADDR_W  byte write address
- load_data  input  8  byte write data
- ready  output  1  high once the clear sweep has finished
- inst  output  IW  fetched instruction, big-endian
- inst_valid  output  1  inst holds the result of a fetch accepted on the previous edge
- misaligned  output  1  the fetched pc was not a multiple of INST_BYTES

Behaviour:
- Reset (rst=1 at an edge):
  - state<=CLEAR, clr_ptr<=0.
  - ready, inst_valid and misaligned <=0; inst<=0.
  - Memory is not written in the reset cycle.
- CLEAR state:
  - Each edge with rst=0 writes mem[clr_ptr]<=0 and increments clr_ptr.
  - The edge that clears byte DEPTH-1 also sets state<=RUN and ready<=1.
  - ready is therefore first seen high after exactly DEPTH edges with rst=0 (256 at the default).
  - During CLEAR, fetch_req, stall and load_en are ignored, inst_valid stays 0 and inst stays 0.
- RUN state: stays in RUN until rst. ready stays 1.
- Fetch (RUN, stall=0, fetch_req=1):
  - Next edge loads inst <= {mem[pc], mem[pc+1], ..., mem[pc+INST_BYTES-1]}. The lowest address goes to the most significant byte.
  - Address arithmetic is modulo DEPTH: at the default, pc=255 returns {mem[255], mem[0]}.
  - inst_valid<=1.
  - misaligned <= (pc mod INST_BYTES != 0). Always 0 when INST_BYTES=1.
  - Data is returned even when misaligned.
- Idle (RUN, stall=0, fetch_req=0): inst_valid<=0 and misaligned<=0; inst holds its last value.
- Stall (RUN, stall=1): inst, inst_valid and misaligned all hold, regardless of fetch_req.
- Load (RUN, load_en=1):
  - mem[load_addr]<=load_data on the edge.
  - Performed independently of stall and fetch_req.
- Same-edge load and fetch touching the same byte: the fetch returns the old byte (read-before-write). A fetch on the next edge sees the new byte.
- Reset mid-operation (during CLEAR or RUN):
  - Aborts everything and restarts the sweep from address 0.
  - All memory contents are lost.
  - Outputs return to their reset values on that edge.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: assert rst 1 cycle, then hold rst=0 -> ready=0 through edge 255 and 1 after edge 256. Fetch pc=0x10 -> inst=0x0000, inst_valid=1 one cycle later.
- Load then fetch:
  - Load 0x70@0x04, 0x00@0x05, 0xE0@0x06, 0xFF@0x07.
  - Fetch pc=4 then pc=6 on back-to-back cycles -> inst=0x7000 then 0xE0FF, inst_valid=1 on both cycles, misaligned=0.
- Wrap and misaligned: load 0xAB@0xFF and 0xCD@0x00, fetch pc=0xFF -> inst=0xABCD, misaligned=1. Next cycle with fetch_req=0 -> inst_valid=0, inst stays 0xABCD.
- Stall: fetch pc=4 (inst=0x7000), then assert stall for 3 cycles while fetch_req=1 with pc=6 -> inst=0x7000 and inst_valid=1 held for all 3 cycles. On release -> inst=0xE0FF.
- Same-edge conflict: mem[0x20]=0x11; on one edge load 0x22@0x20 and fetch pc=0x20 -> inst[15:8]=0x11. Refetch on the next cycle -> 0x22.
- Reset mid-run and parameter sweep:
  - After loads, assert rst -> inst=0, ready=0, sweep restarts. After ready, fetch of a previously loaded pc returns 0.
  - Repeat the load/fetch scenarios at ADDR_W=10, INST_BYTES=4: load 0x12,0x34,0x56,0x78 @0x3FE..0x001, fetch 0x3FE -> inst=0x12345678, misaligned=1.
